regbank_write_arbiter: RTL and testbench

Write controller that shares one bank of gated-enable D flip-flop registers (DFFE cells, one `dEnable` per register, common data bus) between two requesters. It arbitrates round-robin, latches the winning address and data, and sequences each write through setup, enable strobe and hold phases, so every register sees stable data around its enable pulse. It sits between the requesting logic and the register bank and is the only driver of the bank's data and enable lines.

---
 rtl/regbank_write_arbiter.sv | 129 ++++++++++++
 tb/tb_regbank_write_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regbank_write_arbiter.sv
// Round-robin write controller for a bank of DFFE registers sharing one data bus.
// Each write runs IDLE -> SETUP -> STROBE -> HOLD so data is stable around the enable pulse.
module regbank_write_arbiter #(
    parameter int WIDTH  = 4,
    parameter int NREGS  = 4,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [WIDTH-1:0]  data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]  data1,
    output logic              ack1,
    output logic [WIDTH-1:0]  wr_data,
    output logic [NREGS-1:0]  wr_en,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic                last_r, last_s;
    logic                grant_r, grant_s;
    logic                win_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [WIDTH-1:0]    data_r, data_s;
    logic [NREGS-1:0]    wr_en_r, wr_en_s;
    logic                ack0_r, ack0_s;
    logic                ack1_r, ack1_s;
    logic                busy_r, busy_s;

    function automatic logic [NREGS-1:0] addr_decode(input logic [ADDR_W-1:0] a);
        logic [NREGS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // Next-state, arbitration and next-output logic; outputs are registered one cycle ahead.
    always_comb begin
        state_s = state_r;
        last_s  = last_r;
        grant_s = grant_r;
        addr_s  = addr_r;
        data_s  = data_r;
        wr_en_s = '0;
        ack0_s  = 1'b0;
        ack1_s  = 1'b0;
        // A tie goes to whoever was not granted last.
        if (req0 && req1) begin
            win_s = ~last_r;
        end else begin
            win_s = req1;
        end
        case (state_r)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant_s = win_s;
                    last_s  = win_s;
                    addr_s  = win_s ? addr1 : addr0;
                    data_s  = win_s ? data1 : data0;
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                wr_en_s = addr_decode(addr_r);
                state_s = ST_STROBE;
            end
            ST_STROBE: begin
                if (grant_r) begin
                    ack1_s = 1'b1;
                end else begin
                    ack0_s = 1'b1;
                end
                state_s = ST_HOLD;
            end
            ST_HOLD: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers; reset abandons any write in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            last_r  <= 1'b1;
            grant_r <= 1'b0;
            addr_r  <= '0;
            data_r  <= '0;
            wr_en_r <= '0;
            ack0_r  <= 1'b0;
            ack1_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            last_r  <= last_s;
            grant_r <= grant_s;
            addr_r  <= addr_s;
            data_r  <= data_s;
            wr_en_r <= wr_en_s;
            ack0_r  <= ack0_s;
            ack1_r  <= ack1_s;
            busy_r  <= busy_s;
        end
    end

    assign wr_data = data_r;
    assign wr_en   = wr_en_r;
    assign ack0    = ack0_r;
    assign ack1    = ack1_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Scoreboard bench: a transaction-level arbiter model predicts strobes, acks, busy and
// bus data; a negedge monitor compares the DUT against those predictions.
module tb_regbank_write_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [1:0] addr0 = 2'd0, addr1 = 2'd0;
    logic [3:0] data0 = 4'd0, data1 = 4'd0;
    logic       ack0, ack1, busy;
    logic [3:0] wr_data;
    logic [3:0] wr_en;

    regbank_write_arbiter #(.WIDTH(4), .NREGS(4), .ADDR_W(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
        .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
        .wr_data(wr_data), .wr_en(wr_en), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int addr; int data; int edge_n;} stb_t;
    typedef struct {int who; int edge_n;} ack_t;

    stb_t strobe_q[$];
    ack_t ack_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    // reference model state
    int   m_last = 1;
    int   m_next_dec = 0;
    int   m_g_last = -100;
    int   m_d_last = 0;
    int   m_d_prev = 0;
    int   model_mem [4];
    bit   model_wr [4];
    logic [3:0] bank [4];

    task automatic check(input string name, input int act, input int exp);
        vectors = vectors + 1;
        if (act != exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        strobe_q.delete();
        ack_q.delete();
        m_last = 1;
        m_next_dec = 0;
        m_g_last = -100;
        m_d_last = 0;
        m_d_prev = 0;
    endtask

    // Decide the grant the arbiter must make at edge e from the request levels it will sample.
    task automatic model_eval(input int e);
        int win;
        stb_t s;
        ack_t a;
        if (reset_n && e >= m_next_dec && (req0 || req1)) begin
            if (req0 && req1) win = 1 - m_last;
            else win = req1 ? 1 : 0;
            m_last = win;
            s.addr = win ? int'(addr1) : int'(addr0);
            s.data = win ? int'(data1) : int'(data0);
            s.edge_n = e + 1;
            a.who = win;
            a.edge_n = e + 2;
            strobe_q.push_back(s);
            ack_q.push_back(a);
            m_d_prev = m_d_last;
            m_d_last = s.data;
            m_g_last = e;
            m_next_dec = e + 4;
        end
    endtask

    task automatic drive(input logic rn, input logic r0, input logic [1:0] a0, input logic [3:0] d0,
                         input logic r1, input logic [1:0] a1, input logic [3:0] d1);
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        reset_n = rn;
        req0 = r0; addr0 = a0; data0 = d0;
        req1 = r1; addr1 = a1; data1 = d1;
        model_eval(cyc + 1);
    endtask

    // Behavioural DFFE bank fed by the DUT's bus.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) bank[i] <= wr_data;
        end
    end

    // Monitor: compares outputs for the cycle following edge cyc.
    always @(negedge clk) begin
        stb_t s;
        ack_t a;
        check("ack_exclusive", int'(ack0 && ack1), 0);
        check("busy", int'(busy), int'(cyc >= m_g_last && cyc <= m_g_last + 2));
        check("wr_data_bus", int'(wr_data), (cyc >= m_g_last) ? m_d_last : m_d_prev);
        if (wr_en != 4'd0) begin
            if (strobe_q.size() == 0) begin
                check("unexpected_strobe", int'(wr_en), 0);
            end else begin
                s = strobe_q.pop_front();
                check("strobe_en", int'(wr_en), 1 << s.addr);
                check("strobe_data", int'(wr_data), s.data);
                check("strobe_edge", cyc, s.edge_n);
                model_mem[s.addr] = s.data;
                model_wr[s.addr] = 1'b1;
            end
        end else if (strobe_q.size() != 0 && strobe_q[0].edge_n <= cyc) begin
            s = strobe_q.pop_front();
            check("missing_strobe", 0, 1 << s.addr);
        end
        if (ack0 || ack1) begin
            if (ack_q.size() == 0) begin
                check("unexpected_ack", int'({ack1, ack0}), 0);
            end else begin
                a = ack_q.pop_front();
                check("ack_who", ack1 ? 1 : 0, a.who);
                check("ack_edge", cyc, a.edge_n);
            end
        end else if (ack_q.size() != 0 && ack_q[0].edge_n <= cyc) begin
            a = ack_q.pop_front();
            check("missing_ack", 0, a.who + 1);
        end
    end

    initial begin
        logic r0, r1;
        logic [1:0] a0, a1;
        logic [3:0] d0, d1;
        for (int i = 0; i < 4; i++) begin
            model_mem[i] = 0;
            model_wr[i] = 1'b0;
        end
        #3;
        check("reset_wr_en", int'(wr_en), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_wr_data", int'(wr_data), 0);
        check("reset_acks", int'({ack1, ack0}), 0);
        drive(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0);
        // Tie from reset: both held, grants must alternate 0,1,0,1.
        for (int i = 0; i < 17; i++) drive(1'b1, 1'b1, 2'd0, 4'd3, 1'b1, 2'd1, 4'd5);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0);
        // Single write, then a one-cycle request with data changing mid-sequence.
        drive(1'b1, 1'b1, 2'd2, 4'hA, 1'b0, 2'd0, 4'd0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 2'd2, 4'hA, 1'b0, 2'd0, 4'd0);
        drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b1, 2'd3, 4'd7);
        drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'hF);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0);
        drive(1'b1, 1'b1, 2'd1, 4'd1, 1'b0, 2'd0, 4'd0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 2'd1, 4'hF, 1'b0, 2'd0, 4'd0);
        // Randomized traffic: drops after grant, late requests, changing addr/data.
        r0 = 1'b0; r1 = 1'b0; a0 = 2'd0; a1 = 2'd0; d0 = 4'd0; d1 = 4'd0;
        for (int i = 0; i < 1500; i++) begin
            if (r0) r0 = ($urandom_range(7) != 0); else r0 = ($urandom_range(2) == 0);
            if (r1) r1 = ($urandom_range(7) != 0); else r1 = ($urandom_range(2) == 0);
            if ($urandom_range(3) == 0) a0 = 2'($urandom);
            if ($urandom_range(3) == 0) a1 = 2'($urandom);
            if ($urandom_range(3) == 0) d0 = 4'($urandom);
            if ($urandom_range(3) == 0) d1 = 4'($urandom);
            drive(1'b1, r0, a0, d0, r1, a1, d1);
        end
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0);
        // Reset during STROBE: enable drops at once, no ack, then tie restarts with requester 0.
        drive(1'b1, 1'b1, 2'd1, 4'd9, 1'b0, 2'd0, 4'd0);
        drive(1'b1, 1'b0, 2'd1, 4'd9, 1'b0, 2'd0, 4'd0);
        drive(1'b1, 1'b0, 2'd1, 4'd9, 1'b0, 2'd0, 4'd0);
        check("pre_reset_strobe", int'(wr_en), 2);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_wr_en", int'(wr_en), 0);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_wr_data", int'(wr_data), 0);
        check("async_reset_acks", int'({ack1, ack0}), 0);
        drive(1'b0, 1'b1, 2'd2, 4'd6, 1'b1, 2'd3, 4'd8);
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, 2'd2, 4'd6, 1'b1, 2'd3, 4'd8);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0);
        check("strobe_queue_drained", strobe_q.size(), 0);
        check("ack_queue_drained", ack_q.size(), 0);
        for (int i = 0; i < 4; i++) begin
            if (model_wr[i]) check("bank_contents", int'(bank[i]), model_mem[i]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
